// File: rtl/serial_pkg.sv
// Shared serial link definitions.
// Used by both the frame receiver and the matching serializer.
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/sipo_shift.sv
// Shift-enable register collecting serial data bits.
// Bit order selects whether the first bit lands in the MSB or the LSB.
module sipo_shift #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nxt;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_nxt = {r_q[WIDTH-2:0], d};
    end else begin : g_lsb
      assign w_nxt = {d, r_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= w_nxt;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits, stop bit.
// Presents words on a valid/ready port, flags framing and overrun errors.
module sipo_frame_rx
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_frame_err,
  output logic             o_overrun,
  input  logic             i_clr_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_shift_en;
  logic             w_stop;
  logic [WIDTH-1:0] w_word;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;

  logic w_good;
  logic w_slot_free;
  logic w_load;
  logic w_drop;
  logic w_bad;

  sipo_shift #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk(clk),
    .rst(rst),
    .en (w_shift_en),
    .d  (i),
    .q  (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_en  = 1'b0;
    w_stop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i == START_LVL) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        w_shift_en = 1'b1;
        if (r_cnt == LAST) begin
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        w_stop      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The word is complete in the shifter while the stop bit is sampled
  assign w_good      = w_stop && (i == STOP_LVL);
  assign w_bad       = w_stop && (i != STOP_LVL);
  assign w_slot_free = !r_valid || i_ready;
  assign w_load      = w_good && w_slot_free;
  assign w_drop      = w_good && !w_slot_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_ferr <= w_bad;
      if (i_clr_err) begin
        r_ovr <= 1'b0;
      end else if (w_drop) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_frame_err = r_ferr;
  assign o_overrun   = r_ovr;

endmodule
